// File: rtl/bp_be_pkg.sv
// Shared types for the backend integer-regfile writeback path: writeback source
// select encoding and the starvation-counter width helper.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_wb_src_pipe = 2'd0,
    e_wb_src_cfg  = 2'd1,
    e_wb_src_long = 2'd2
  } bp_be_wb_src_e;

  localparam int starve_limit_default_lp = 8;

  // Counter must be able to hold starve_limit itself (saturation value).
  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bp_be_irf_scoreboard.sv
// Pending-write scoreboard for long-latency destinations with three read ports.
// BP_BE_IRF_WB_BYPASS_EN lets a same-cycle clear hide a busy source register.
module bp_be_irf_scoreboard
  import bp_be_pkg::*;
#(
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        i_set_v,
  input  logic [reg_addr_width_p-1:0] i_set_addr,
  input  logic                        i_clr_v,
  input  logic [reg_addr_width_p-1:0] i_clr_addr,
  input  logic [reg_addr_width_p-1:0] i_rs1_addr,
  input  logic [reg_addr_width_p-1:0] i_rs2_addr,
  input  logic [reg_addr_width_p-1:0] i_rd_addr,
  output logic                        o_hazard
);

  localparam int num_regs_lp = 2 ** reg_addr_width_p;

  logic [num_regs_lp-1:0] r_busy;
  logic [num_regs_lp-1:0] w_set;
  logic [num_regs_lp-1:0] w_clr;
  logic [num_regs_lp-1:0] w_busy_next;
  logic [num_regs_lp-1:0] w_src_mask;

  genvar gi;
  generate
    for (gi = 0; gi < num_regs_lp; gi++) begin : g_decode
      if (gi == 0) begin : g_x0
        assign w_set[gi] = 1'b0;
      end else begin : g_xn
        assign w_set[gi] = i_set_v & (i_set_addr == reg_addr_width_p'(gi));
      end
      assign w_clr[gi] = i_clr_v & (i_clr_addr == reg_addr_width_p'(gi));
    end
  endgenerate

  // Set is applied after clear so a re-issue to the same rd stays outstanding.
  assign w_busy_next = (r_busy & ~w_clr) | w_set;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

`ifdef BP_BE_IRF_WB_BYPASS_EN
  assign w_src_mask = r_busy & ~(w_clr & ~w_set);
`else
  assign w_src_mask = r_busy;
`endif

  assign o_hazard = w_src_mask[i_rs1_addr] | w_src_mask[i_rs2_addr] | r_busy[i_rd_addr];

endmodule

// File: rtl/bp_be_irf_wb_scheduler.sv
// Arbitrates the single integer-regfile write port among commit pipe, cfg debug
// write and long-latency unit, with starvation relief. Macro: BP_BE_IRF_WB_BYPASS_EN.
module bp_be_irf_wb_scheduler
  import bp_be_pkg::*;
#(
  parameter int reg_addr_width_p = 5,
  parameter int dword_width_p    = 64,
  parameter int starve_limit_p   = starve_limit_default_lp
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        pipe_v_i,
  input  logic [reg_addr_width_p-1:0] pipe_addr_i,
  input  logic [dword_width_p-1:0]    pipe_data_i,
  input  logic                        long_v_i,
  input  logic [reg_addr_width_p-1:0] long_addr_i,
  input  logic [dword_width_p-1:0]    long_data_i,
  output logic                        long_ready_o,
  input  logic                        cfg_w_v_i,
  input  logic [reg_addr_width_p-1:0] cfg_addr_i,
  input  logic [dword_width_p-1:0]    cfg_data_i,
  output logic                        cfg_ready_o,
  input  logic                        long_issue_v_i,
  input  logic [reg_addr_width_p-1:0] long_issue_addr_i,
  input  logic [reg_addr_width_p-1:0] rs1_addr_i,
  input  logic [reg_addr_width_p-1:0] rs2_addr_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  output logic                        hazard_o,
  output logic                        pipe_stall_o,
  output logic                        rd_w_v_o,
  output logic [reg_addr_width_p-1:0] rd_addr_o,
  output logic [dword_width_p-1:0]    rd_data_o
);

  localparam int cnt_w_lp = starve_cnt_width(starve_limit_p);
  localparam logic [cnt_w_lp-1:0] limit_lp    = cnt_w_lp'(starve_limit_p);
  localparam logic [cnt_w_lp-1:0] limit_m1_lp = cnt_w_lp'(starve_limit_p - 1);

  logic [cnt_w_lp-1:0] r_starve_cnt;
  logic                r_stall;

  bp_be_wb_src_e w_src;
  logic          w_src_v;
  logic          w_long_win;
  logic          w_cfg_win;
  logic          w_long_denied;
  logic          w_stall_req;

  // The pipe cannot be held, so it wins even in a relief cycle.
  always_comb begin
    w_src   = e_wb_src_pipe;
    w_src_v = 1'b0;
    if (pipe_v_i) begin
      w_src   = e_wb_src_pipe;
      w_src_v = 1'b1;
    end else if (long_v_i && (r_stall || !cfg_w_v_i)) begin
      w_src   = e_wb_src_long;
      w_src_v = 1'b1;
    end else if (cfg_w_v_i) begin
      w_src   = e_wb_src_cfg;
      w_src_v = 1'b1;
    end
  end

  assign w_long_win    = w_src_v & (w_src == e_wb_src_long);
  assign w_cfg_win     = w_src_v & (w_src == e_wb_src_cfg);
  assign w_long_denied = long_v_i & ~w_long_win;
  assign w_stall_req   = w_long_denied & (r_starve_cnt == limit_m1_lp);

  // Outputs are forced low while reset is held, independent of the clock.
  assign long_ready_o = reset_n_i & w_long_win;
  assign cfg_ready_o  = reset_n_i & w_cfg_win;
  assign pipe_stall_o = reset_n_i & w_stall_req;
  assign rd_w_v_o     = reset_n_i & w_src_v;

  always_comb begin
    rd_addr_o = '0;
    rd_data_o = '0;
    if (reset_n_i && w_src_v) begin
      case (w_src)
        e_wb_src_cfg: begin
          rd_addr_o = cfg_addr_i;
          rd_data_o = cfg_data_i;
        end
        e_wb_src_long: begin
          rd_addr_o = long_addr_i;
          rd_data_o = long_data_i;
        end
        default: begin
          rd_addr_o = pipe_addr_i;
          rd_data_o = pipe_data_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_stall <= w_stall_req;
      if (w_long_denied) begin
        if (r_starve_cnt != limit_lp) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

  bp_be_irf_scoreboard #(
    .reg_addr_width_p(reg_addr_width_p)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .i_set_v    (long_issue_v_i),
    .i_set_addr (long_issue_addr_i),
    .i_clr_v    (w_long_win),
    .i_clr_addr (long_addr_i),
    .i_rs1_addr (rs1_addr_i),
    .i_rs2_addr (rs2_addr_i),
    .i_rd_addr  (rd_addr_i),
    .o_hazard   (hazard_o)
  );

endmodule
